// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared types and defaults for tick generator/meter blocks
package tick_pkg;

  localparam int TICK_WINDOW_DEFAULT = 1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } tick_state_e;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered previous value with sync clear; 0->1 pulse while enabled
module rise_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_prev <= 1'b0;
    end else if (i_en) begin
      r_prev <= i_d;
    end
  end

  // Previous value only advances on enabled cycles, so gaps never fake an edge.
  assign o_rise = i_en & i_d & ~r_prev;

endmodule

// File: rtl/tick_meter.sv
// rtl/tick_meter.sv - counts high cycles and rising edges of a tick over a fixed window
// and compares both against expectations latched at start.
module tick_meter
  import tick_pkg::*;
#(
  parameter int WINDOW = TICK_WINDOW_DEFAULT,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_tick_in,
  input  logic [CNT_W-1:0] i_exp_high,
  input  logic [CNT_W-1:0] i_exp_edges,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_high_count,
  output logic [CNT_W-1:0] o_edge_count,
  output logic             o_pass
);

  localparam logic [CNT_W-1:0] LP_LAST_SAMPLE = CNT_W'(WINDOW - 1);

  tick_state_e      r_state;
  tick_state_e      w_state_nxt;
  logic             w_accept;
  logic             w_measure;
  logic             w_last;
  logic             w_rise;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_exp_high;
  logic [CNT_W-1:0] r_exp_edges;
  logic             r_done;
  logic             r_pass;

  assign w_measure = (r_state == ST_MEASURE);
  assign w_accept  = (r_state == ST_IDLE) && i_start;
  assign w_last    = w_measure && (r_sample_cnt == LP_LAST_SAMPLE);

  rise_detect u_rise_detect (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_accept),
    .i_en    (w_measure),
    .i_d     (i_tick_in),
    .o_rise  (w_rise)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (w_last)  w_state_nxt = ST_REPORT;
      ST_REPORT:  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Results persist after REPORT until the next accepted start clears them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sample_cnt <= '0;
      r_high_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_exp_high   <= '0;
      r_exp_edges  <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sample_cnt <= '0;
        r_high_cnt   <= '0;
        r_edge_cnt   <= '0;
        r_exp_high   <= i_exp_high;
        r_exp_edges  <= i_exp_edges;
        r_pass       <= 1'b0;
      end else if (w_measure) begin
        r_sample_cnt <= r_sample_cnt + 1'b1;
        r_high_cnt   <= r_high_cnt + {{(CNT_W-1){1'b0}}, i_tick_in};
        r_edge_cnt   <= r_edge_cnt + {{(CNT_W-1){1'b0}}, w_rise};
      end else if (r_state == ST_REPORT) begin
        r_pass <= (r_high_cnt == r_exp_high) && (r_edge_cnt == r_exp_edges);
        r_done <= 1'b1;
      end
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_high_count = r_high_cnt;
  assign o_edge_count = r_edge_cnt;
  assign o_pass       = r_pass;

endmodule

// File: tb/tb_tick_meter.sv
// tb/tb_tick_meter.sv - directed self-checking bench for tick_meter
module tb_tick_meter;

  localparam int WINDOW = 1000;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             tick_in;
  logic [CNT_W-1:0] exp_high;
  logic [CNT_W-1:0] exp_edges;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] edge_count;
  logic             pass;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tick_meter #(.WINDOW(WINDOW)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_tick_in    (tick_in),
    .i_exp_high   (exp_high),
    .i_exp_edges  (exp_edges),
    .o_busy       (busy),
    .o_done       (done),
    .o_high_count (high_count),
    .o_edge_count (edge_count),
    .o_pass       (pass)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // p=0 constant low, p=1 constant high, otherwise square wave of period p starting high
  function automatic logic tick_at(input int p, input int k);
    if (p == 0) return 1'b0;
    if (p == 1) return 1'b1;
    return ((k % p) < (p / 2));
  endfunction

  // Starts one window; restart_at / reset_at pulse start / reset before sample k (-1 = never).
  task automatic run(input string tag, input int p, input int eh, input int ee,
                     input int restart_at, input int reset_at,
                     output int lat, output int done_seen);
    exp_high  = CNT_W'(eh);
    exp_edges = CNT_W'(ee);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, "_busy_after_start"}, busy, 1);
    lat       = -1;
    done_seen = 0;
    for (int k = 0; k < WINDOW + 8; k++) begin
      tick_in = (k < WINDOW) ? tick_at(p, k) : 1'b0;
      start   = (k == restart_at);
      reset   = (k == reset_at);
      @(posedge clk); #1;
      if (done) begin
        done_seen++;
        if (lat < 0) begin
          lat = k + 2;
          check_eq({tag, "_busy_at_done"}, busy, 0);
        end
      end
      if (k == reset_at) begin
        check_eq({tag, "_busy_after_reset"}, busy, 0);
        check_eq({tag, "_high_after_reset"}, high_count, 0);
        check_eq({tag, "_edges_after_reset"}, edge_count, 0);
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic full_window(input string tag, input int p, input int eh, input int ee,
                             input int restart_at, input int want_h, input int want_e,
                             input int want_pass);
    int lat, seen;
    run(tag, p, eh, ee, restart_at, -1, lat, seen);
    check_eq({tag, "_latency"}, lat, 1002);
    check_eq({tag, "_done_pulses"}, seen, 1);
    check_eq({tag, "_high"}, high_count, want_h);
    check_eq({tag, "_edges"}, edge_count, want_e);
    check_eq({tag, "_pass"}, pass, want_pass);
  endtask

  initial begin
    int lat, seen;
    int t_done[$];
    reset     = 1'b1;
    start     = 1'b0;
    tick_in   = 1'b0;
    exp_high  = '0;
    exp_edges = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_high", high_count, 0);
    check_eq("rst_edges", edge_count, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    full_window("p50",    50, 500,  20, -1,  500,  20, 1);
    full_window("toggle",  2, 500, 500, -1,  500, 500, 1);
    full_window("const1",  1, 1000,  1, -1, 1000,   1, 1);
    full_window("const0",  0,    0,  0, -1,    0,   0, 1);
    full_window("p20bad", 20, 500,  20, -1,  500,  50, 0);
    full_window("restart",50, 500,  20, 300, 500,  20, 1);

    run("abort", 50, 500, 20, -1, 400, lat, seen);
    check_eq("abort_done_pulses", seen, 0);
    check_eq("abort_busy_end", busy, 0);
    check_eq("abort_high_end", high_count, 0);

    start = 1'b1;
    exp_high  = CNT_W'(500);
    exp_edges = CNT_W'(500);
    for (int g = 0; g < 3 * (WINDOW + 2) + 20 && t_done.size() < 3; g++) begin
      tick_in = g[0];
      @(posedge clk); #1;
      if (done) begin
        t_done.push_back(g);
        if (t_done.size() == 3) start = 1'b0;
        check_eq("b2b_high", high_count, 500);
        check_eq("b2b_edges", edge_count, 500);
        check_eq("b2b_pass", pass, 1);
      end
    end
    check_eq("b2b_done_count", t_done.size(), 3);
    if (t_done.size() == 3) begin
      check_eq("b2b_spacing1", t_done[1] - t_done[0], WINDOW + 2);
      check_eq("b2b_spacing2", t_done[2] - t_done[1], WINDOW + 2);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("b2b_idle_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
